// File: rtl/grid_pkg.sv
// Shared types and cell codes for the grid cursor navigator.
package grid_pkg;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StSeek  = 2'd1;
  localparam state_t StReloc = 2'd2;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirDown  = 2'd1,
    DirLeft  = 2'd2,
    DirRight = 2'd3
  } dir_e;

  localparam logic [4:0] CodeAdd  = 5'b10000;
  localparam logic [4:0] CodeMul  = 5'b10001;
  localparam logic [4:0] CodeAnd  = 5'b10010;
  localparam logic [4:0] CodeExe  = 5'b10011;
  localparam logic [4:0] CodeSub  = 5'b10100;
  localparam logic [4:0] CodeOr   = 5'b10101;
  localparam logic [4:0] CodeCe   = 5'b10110;
  localparam logic [4:0] CodeClr  = 5'b10111;
  localparam logic [4:0] CodeNone = 5'h1F;

endpackage

// File: rtl/grid_val_map.sv
// Combinational cell lookup: (x, y, restriction) -> cell code and forbidden flag.
module grid_val_map import grid_pkg::*; #(
  parameter int unsigned COLS = 6,
  parameter int unsigned ROWS = 4
) (
  input  logic [$clog2(COLS)-1:0] x_i,
  input  logic [$clog2(ROWS)-1:0] y_i,
  input  logic                    restriction_i,
  output logic [4:0]              code_o,
  output logic                    forbidden_o
);

  int unsigned xi, yi;

  always_comb begin
    xi     = 32'(x_i);
    yi     = 32'(y_i);
    code_o = CodeNone;
    if (xi < COLS && yi < ROWS) begin
      // Hex digits fill a 4x4 block with 0 in the bottom-left corner.
      if (xi < 4) begin
        code_o = 5'((3 - yi) * 4 + xi);
      end else if (xi == 4) begin
        case (yi)
          0:       code_o = CodeMul;
          1:       code_o = CodeAdd;
          2:       code_o = CodeAnd;
          default: code_o = CodeCe;
        endcase
      end else if (xi == 5) begin
        case (yi)
          0:       code_o = CodeClr;
          1:       code_o = CodeSub;
          2:       code_o = CodeOr;
          default: code_o = CodeExe;
        endcase
      end
    end
    forbidden_o = (code_o == CodeNone) ||
                  (restriction_i && code_o >= 5'h0A && code_o <= 5'h0F);
  end

endmodule

// File: rtl/grid_cursor_nav.sv
// Keypad-grid cursor: edge/auto-repeat direction input, skip-search over forbidden
// cells, relocation when the current cell becomes forbidden, and value capture.
module grid_cursor_nav import grid_pkg::*; #(
  parameter int unsigned COLS       = 6,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned REPEAT_DLY = 12_500_000,
  parameter int unsigned REPEAT_PER = 2_500_000,
  parameter int unsigned SAFE_X     = 0,
  parameter int unsigned SAFE_Y     = ROWS - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    restriction,
  input  logic                    wrap_en,
  input  logic                    dir_up,
  input  logic                    dir_down,
  input  logic                    dir_left,
  input  logic                    dir_right,
  input  logic                    sel,
  output logic [$clog2(COLS)-1:0] pos_x,
  output logic [$clog2(ROWS)-1:0] pos_y,
  output logic [4:0]              val,
  output logic [4:0]              val_out,
  output logic                    val_strobe,
  output logic                    moved,
  output logic                    busy
);

  localparam int unsigned XW = $clog2(COLS);
  localparam int unsigned YW = $clog2(ROWS);

  state_t           state_q, state_d;
  dir_e             dir_q, dir_d, req_dir, src_dir;
  logic [XW-1:0]    pos_x_q, pos_x_d, cand_x_q, cand_x_d, src_x, nb_x;
  logic [YW-1:0]    pos_y_q, pos_y_d, cand_y_q, cand_y_d, src_y, nb_y;
  logic [3:0]       step_q, step_d;
  logic [4:0]       val_out_q, val_out_d, cand_code;
  logic             val_strobe_q, val_strobe_d, moved_q, moved_d;
  logic             cur_forbidden, cand_forbidden, nb_edge;
  logic [3:0]       dir_in, prev_q, rise, rpt_tick, req;
  logic [3:0][31:0] rpt_q, rpt_d;
  logic [3:0]       phase_q, phase_d;
  int unsigned      lim;

  grid_val_map #(.COLS(COLS), .ROWS(ROWS)) u_cur_map (
    .x_i(pos_x_q), .y_i(pos_y_q), .restriction_i(restriction),
    .code_o(val), .forbidden_o(cur_forbidden)
  );

  grid_val_map #(.COLS(COLS), .ROWS(ROWS)) u_cand_map (
    .x_i(cand_x_q), .y_i(cand_y_q), .restriction_i(restriction),
    .code_o(cand_code), .forbidden_o(cand_forbidden)
  );

  assign dir_in = {dir_right, dir_left, dir_down, dir_up};
  assign rise   = dir_in & ~prev_q;
  assign req    = rise | rpt_tick;

  // rpt_q holds k, the number of cycles since the press edge (phase 1: since last tick).
  always_comb begin
    rpt_d    = rpt_q;
    phase_d  = phase_q;
    rpt_tick = '0;
    for (int i = 0; i < 4; i++) begin
      if (!dir_in[i]) begin
        rpt_d[i]   = '0;
        phase_d[i] = 1'b0;
      end else if (!prev_q[i]) begin
        rpt_d[i]   = 32'd1;
        phase_d[i] = 1'b0;
      end else if (rpt_q[i] == (phase_q[i] ? 32'(REPEAT_PER) : 32'(REPEAT_DLY))) begin
        rpt_tick[i] = 1'b1;
        rpt_d[i]    = 32'd1;
        phase_d[i]  = 1'b1;
      end else begin
        rpt_d[i] = rpt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    if (req[0])      req_dir = DirUp;
    else if (req[1]) req_dir = DirDown;
    else if (req[2]) req_dir = DirLeft;
    else             req_dir = DirRight;
  end

  // One neighbour stepper shared by the IDLE launch and the SEEK advance.
  always_comb begin
    src_x   = (state_q == StIdle) ? pos_x_q : cand_x_q;
    src_y   = (state_q == StIdle) ? pos_y_q : cand_y_q;
    src_dir = (state_q == StIdle) ? req_dir : dir_q;
    nb_x    = src_x;
    nb_y    = src_y;
    nb_edge = 1'b0;
    unique case (src_dir)
      DirUp: begin
        if (src_y == '0) begin
          if (wrap_en) nb_y = YW'(ROWS - 1);
          else         nb_edge = 1'b1;
        end else nb_y = src_y - 1'b1;
      end
      DirDown: begin
        if (src_y == YW'(ROWS - 1)) begin
          if (wrap_en) nb_y = '0;
          else         nb_edge = 1'b1;
        end else nb_y = src_y + 1'b1;
      end
      DirLeft: begin
        if (src_x == '0) begin
          if (wrap_en) nb_x = XW'(COLS - 1);
          else         nb_edge = 1'b1;
        end else nb_x = src_x - 1'b1;
      end
      DirRight: begin
        if (src_x == XW'(COLS - 1)) begin
          if (wrap_en) nb_x = '0;
          else         nb_edge = 1'b1;
        end else nb_x = src_x + 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    dir_d        = dir_q;
    step_d       = step_q;
    val_out_d    = val_out_q;
    val_strobe_d = 1'b0;
    moved_d      = 1'b0;
    lim          = (dir_q == DirLeft || dir_q == DirRight) ? COLS : ROWS;
    case (state_q)
      StIdle: begin
        if (sel) begin
          val_out_d    = val;
          val_strobe_d = 1'b1;
        end
        if (cur_forbidden) begin
          state_d = StReloc;
        end else if (|req && !nb_edge) begin
          cand_x_d = nb_x;
          cand_y_d = nb_y;
          dir_d    = req_dir;
          step_d   = 4'd1;
          state_d  = StSeek;
        end
      end
      StSeek: begin
        if (!cand_forbidden && cand_code != CodeNone) begin
          pos_x_d = cand_x_q;
          pos_y_d = cand_y_q;
          moved_d = 1'b1;
          state_d = StIdle;
        end else if (nb_edge || (32'(step_q) + 1) >= lim) begin
          state_d = StIdle;
        end else begin
          cand_x_d = nb_x;
          cand_y_d = nb_y;
          step_d   = step_q + 4'd1;
        end
      end
      StReloc: begin
        pos_x_d = XW'(SAFE_X);
        pos_y_d = YW'(SAFE_Y);
        moved_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      dir_q        <= DirUp;
      step_q       <= '0;
      val_out_q    <= '0;
      val_strobe_q <= 1'b0;
      moved_q      <= 1'b0;
      prev_q       <= '0;
      rpt_q        <= '0;
      phase_q      <= '0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      val_out_q    <= val_out_d;
      val_strobe_q <= val_strobe_d;
      moved_q      <= moved_d;
      prev_q       <= dir_in;
      rpt_q        <= rpt_d;
      phase_q      <= phase_d;
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign val_out    = val_out_q;
  assign val_strobe = val_strobe_q;
  assign moved      = moved_q;
  assign busy       = (state_q == StSeek);

endmodule

// File: tb/tb_grid_cursor_nav.sv
// Directed bench for grid_cursor_nav with a queue of expected move outcomes.
module tb_grid_cursor_nav;

  logic       clk = 1'b0;
  logic       rst, restriction, wrap_en, sel;
  logic       dir_up, dir_down, dir_left, dir_right;
  logic [2:0] pos_x;
  logic [1:0] pos_y;
  logic [4:0] val, val_out;
  logic       val_strobe, moved, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int moved_cnt = 0;

  typedef struct {
    string tag;
    int    x;
    int    y;
    int    v;
    int    seek;
    int    mv;
  } exp_t;

  exp_t sb[$];

  grid_cursor_nav #(
    .COLS(6), .ROWS(4), .REPEAT_DLY(8), .REPEAT_PER(4)
  ) dut (
    .clk(clk), .rst(rst), .restriction(restriction), .wrap_en(wrap_en),
    .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
    .sel(sel), .pos_x(pos_x), .pos_y(pos_y), .val(val), .val_out(val_out),
    .val_strobe(val_strobe), .moved(moved), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (moved) moved_cnt <= moved_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int expv);
    n_tests++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // Pulse a direction set for one cycle, wait for SEEK to finish, then score.
  task automatic do_move(input logic [3:0] d, input string tag,
                         input int ex, input int ey, input int ev,
                         input int es, input int em);
    exp_t e;
    int   seek;
    int   m0;
    e.tag = tag; e.x = ex; e.y = ey; e.v = ev; e.seek = es; e.mv = em;
    sb.push_back(e);
    m0 = moved_cnt;
    {dir_right, dir_left, dir_down, dir_up} = d;
    tick();
    {dir_right, dir_left, dir_down, dir_up} = 4'b0000;
    seek = 0;
    while (busy && seek < 20) begin
      seek++;
      tick();
    end
    tick();
    e = sb.pop_front();
    chk({e.tag, "_x"}, int'(pos_x), e.x);
    chk({e.tag, "_y"}, int'(pos_y), e.y);
    chk({e.tag, "_val"}, int'(val), e.v);
    chk({e.tag, "_seek"}, seek, e.seek);
    chk({e.tag, "_moves"}, moved_cnt - m0, e.mv);
  endtask

  localparam logic [3:0] Up = 4'b0001, Down = 4'b0010, Left = 4'b0100, Right = 4'b1000;

  initial begin
    int m0;
    int row3[6];
    row3 = '{0, 1, 2, 3, 'h16, 'h13};
    rst = 1'b1; restriction = 1'b0; wrap_en = 1'b0; sel = 1'b0;
    {dir_right, dir_left, dir_down, dir_up} = 4'b0000;
    tick();
    tick();
    chk("rst_x", int'(pos_x), 0);
    chk("rst_y", int'(pos_y), 0);
    chk("rst_val", int'(val), 'h0C);
    chk("rst_val_out", int'(val_out), 0);
    chk("rst_strobe", int'(val_strobe), 0);
    chk("rst_moved", int'(moved), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();

    do_move(Down,  "down_01", 0, 1, 8, 1, 1);
    do_move(Right, "right_11", 1, 1, 9, 1, 1);
    restriction = 1'b1;
    do_move(Right, "skip_right", 4, 1, 'h10, 3, 1);
    do_move(Left,  "skip_left", 1, 1, 9, 3, 1);
    do_move(Left,  "left_01", 0, 1, 8, 1, 1);
    do_move(Up,    "up_blocked", 0, 1, 8, 1, 0);
    restriction = 1'b0;
    do_move(Down,  "down_02", 0, 2, 4, 1, 1);
    do_move(Down,  "down_03", 0, 3, 0, 1, 1);
    for (int i = 1; i < 6; i++) do_move(Right, "row3_walk", i, 3, row3[i], 1, 1);

    sel = 1'b1;
    tick();
    sel = 1'b0;
    chk("sel_exe_val_out", int'(val_out), 'h13);
    chk("sel_exe_strobe", int'(val_strobe), 1);
    tick();
    chk("sel_exe_strobe_off", int'(val_strobe), 0);

    do_move(Right, "edge_nowrap", 5, 3, 'h13, 0, 0);
    wrap_en = 1'b1;
    do_move(Right, "edge_wrap", 0, 3, 0, 1, 1);
    restriction = 1'b1;
    do_move(Left,  "wrap_left", 5, 3, 'h13, 1, 1);
    restriction = 1'b0;
    wrap_en = 1'b0;
    do_move(Up | Left, "priority", 5, 2, 'h15, 1, 1);
    do_move(Down,  "back_53", 5, 3, 'h13, 1, 1);
    wrap_en = 1'b1;
    do_move(Right, "to_03", 0, 3, 0, 1, 1);
    wrap_en = 1'b0;

    // Held right: press edge plus repeat ticks at k=8,12,16.
    begin
      exp_t e;
      e.tag = "repeat"; e.x = 4; e.y = 3; e.v = 'h16; e.seek = 0; e.mv = 4;
      sb.push_back(e);
      m0 = moved_cnt;
      dir_right = 1'b1;
      repeat (17) tick();
      dir_right = 1'b0;
      repeat (4) tick();
      e = sb.pop_front();
      chk("repeat_x", int'(pos_x), e.x);
      chk("repeat_y", int'(pos_y), e.y);
      chk("repeat_val", int'(val), e.v);
      chk("repeat_moves", moved_cnt - m0, e.mv);
    end

    // Reset in the middle of a SEEK.
    m0 = moved_cnt;
    dir_left = 1'b1;
    tick();
    dir_left = 1'b0;
    chk("seek_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    chk("seek_rst_x", int'(pos_x), 0);
    chk("seek_rst_y", int'(pos_y), 0);
    chk("seek_rst_busy", int'(busy), 0);
    chk("seek_rst_moved", int'(moved), 0);
    rst = 1'b0;
    tick();
    tick();
    chk("seek_rst_moves", moved_cnt - m0, 0);
    chk("seek_rst_val", int'(val), 'h0C);

    // Relocation when the current cell becomes forbidden.
    m0 = moved_cnt;
    restriction = 1'b1;
    tick();
    chk("reloc_wait_y", int'(pos_y), 0);
    tick();
    chk("reloc_x", int'(pos_x), 0);
    chk("reloc_y", int'(pos_y), 3);
    chk("reloc_moved", int'(moved), 1);
    tick();
    chk("reloc_moved_off", int'(moved), 0);
    chk("reloc_moves", moved_cnt - m0, 1);
    sel = 1'b1;
    tick();
    sel = 1'b0;
    chk("sel0_val_out", int'(val_out), 0);
    chk("sel0_strobe", int'(val_strobe), 1);
    tick();
    chk("sel0_strobe_off", int'(val_strobe), 0);

    // Restriction already high when reset releases.
    rst = 1'b1;
    tick();
    tick();
    chk("rrst_y", int'(pos_y), 0);
    chk("rrst_val_out", int'(val_out), 0);
    m0 = moved_cnt;
    rst = 1'b0;
    tick();
    chk("rrst_first_y", int'(pos_y), 0);
    tick();
    chk("rrst_reloc_x", int'(pos_x), 0);
    chk("rrst_reloc_y", int'(pos_y), 3);
    tick();
    chk("rrst_moves", moved_cnt - m0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_cursor_nav.md
GRID_CURSOR_NAV -- requirements
Module: grid_cursor_nav

Interface
REQ-001 Parameter COLS, default 6: grid columns (2..8).
REQ-002 Parameter ROWS, default 4: grid rows (2..4).
REQ-003 Parameter REPEAT_DLY, default 12_500_000: held cycles before first auto-repeat.
REQ-004 Parameter REPEAT_PER, default 2_500_000: cycles between auto-repeats (>=4).
REQ-005 Parameter SAFE_X/SAFE_Y, default 0/ROWS-1: relocation cell when restricted.
REQ-006 clk  in  1  VGA pixel clock; the only clock.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 restriction  in  1  level; 1 = DEC mode, hex-digit cells forbidden.
REQ-009 wrap_en  in  1  level; 1 = moves past an edge wrap to the opposite edge.
REQ-010 dir_up, dir_down, dir_left, dir_right  in  1 each  level, held while key pressed.
REQ-011 sel  in  1  one-cycle pulse requesting capture of the current cell value.
REQ-012 pos_x  out  $clog2(COLS)  cursor column; pos_y  out  $clog2(ROWS)  cursor row.
REQ-013 val  out  5  combinational code of cell (pos_x,pos_y).
REQ-014 val_out  out  5  registered captured value; val_strobe  out  1  one-cycle capture pulse.
REQ-015 moved  out  1  one-cycle pulse on each position change; busy  out  1  high in SEEK.

Function
REQ-016 Cell map (default size): row0 C D E F MUL CLR; row1 8 9 A B ADD SUB; row2 4 5 6 7 AND OR; row3 0 1 2 3 CE EXE; cells outside the defined map return 5'h1F.
REQ-017 A cell is forbidden when restriction=1 and its code is 5'hA..5'hF; code 5'h1F cells are always forbidden.
REQ-018 Direction request: rising edge of a dir input (registered previous level), or an auto-repeat tick.
REQ-019 Auto-repeat: per held direction, k=0 at press edge; ticks at k=REPEAT_DLY, then every REPEAT_PER while held; release clears counter.
REQ-020 Simultaneous requests: one accepted per cycle, priority up > down > left > right; others dropped.
REQ-021 Requests and sel arriving while busy=1 are dropped.
REQ-022 FSM states: IDLE, SEEK, RELOC.
REQ-023 IDLE + accepted request: cand = neighbour in that direction, step count = 1, go to SEEK.
REQ-024 Neighbour past an edge: wrap_en=1 gives the opposite edge cell; wrap_en=0 ends the search with no move.
REQ-025 SEEK, cand allowed: pos <= cand, moved=1 for one cycle, go to IDLE.
REQ-026 SEEK, cand forbidden: advance cand one cell in the same direction, step count +1, one cell per cycle.
REQ-027 SEEK terminates without move (IDLE, no moved pulse) on an edge with wrap_en=0, or when step count reaches COLS (horizontal) / ROWS (vertical).
REQ-028 Latency: with an allowed neighbour, pos changes at the second rising edge after the request is sampled; each skipped cell adds one cycle.
REQ-029 IDLE with the current cell forbidden: go to RELOC; next cycle pos <= (SAFE_X,SAFE_Y), moved=1, go to IDLE. This check has priority over requests.
REQ-030 sel in IDLE: val_out <= val, val_strobe=1 on the next cycle.
REQ-031 Changes to wrap_en or restriction during SEEK take effect on the next candidate evaluated.

Reset
REQ-032 rst=1: pos_x=0, pos_y=0, state IDLE, val_out=0, val_strobe=0, moved=0, busy=0, repeat counters and edge registers cleared.
REQ-033 rst asserted mid-SEEK or mid-RELOC aborts the operation with no moved pulse.
REQ-034 If restriction=1 after reset, the relocation rule (REQ-029) applies from the first post-reset cycle.

Structure
REQ-035 Package grid_pkg holds the state enum, direction enum and the 5-bit operator codes (ADD 10000, MUL 10001, AND 10010, EXE 10011, SUB 10100, OR 10101, CE 10110, CLR 10111).
REQ-036 Sub-module grid_val_map: combinational (x,y,restriction) -> (code, forbidden), instantiated twice (current cell, candidate).

Verification
REQ-037 restriction=1, at (1,1), press right -> skips (2,1),(3,1); pos=(4,1) after 3 SEEK cycles, exactly 1 moved pulse, val=5'b10000.
REQ-038 wrap_en=0 at (5,3), press right -> pos stays (5,3), no moved; wrap_en=1 -> pos=(0,3), val=0.
REQ-039 restriction=1 at (0,1), press up -> (0,0) forbidden, top edge, no wrap -> pos stays (0,1), no moved.
REQ-040 REPEAT_DLY=8, REPEAT_PER=4, restriction=0, from (0,3) hold right for k=0..16 -> 4 moved pulses, pos=(4,3).
REQ-041 At (0,0), raise restriction -> RELOC; pos=(0,3), one moved pulse; then sel -> val_out=0, val_strobe one cycle.
REQ-042 rst asserted during SEEK -> next cycle pos=(0,0), busy=0, no moved pulse.
